// File: rtl/inst_pkg.sv
// Shared instruction-type enumeration and RV32I opcode constants for the
// encoder and the opcode/type decoder.
package inst_pkg;

    localparam int unsigned INST_W = 32;

    // Instruction format type; encoding 3'd7 is reserved and treated as illegal.
    typedef enum logic [2:0] {
        INST_I     = 3'd0,
        INST_ISTAR = 3'd1,
        INST_S     = 3'd2,
        INST_B     = 3'd3,
        INST_U     = 3'd4,
        INST_J     = 3'd5,
        INST_R     = 3'd6
    } inst_type_t;

    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] AUIPC  = 7'h17;
    localparam logic [6:0] SYSTEM = 7'h73;

endpackage

// File: rtl/inst_field_packer.sv
// Combinational packing of RV32I fields into one instruction word.
module inst_field_packer
    import inst_pkg::*;
(
    input  logic [2:0]        inst_type,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic [INST_W-1:0] word_c,
    output logic              illegal_c
);

    // Reserved type or a non-32-bit opcode (low bits not 2'b11) is rejected.
    always_comb begin
        illegal_c = (inst_type == 3'd7) || (opcode[1:0] != 2'b11);
    end

    // Field placement per format; unused immediate bits fall off.
    always_comb begin
        word_c = '0;
        case (inst_type)
            INST_R:     word_c = {funct7, rs2, rs1, funct3, rd, opcode};
            INST_I:     word_c = {imm[11:0], rs1, funct3, rd, opcode};
            INST_ISTAR: word_c = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            INST_S:     word_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            INST_B:     word_c = {imm[12], imm[10:5], rs2, rs1, funct3,
                                  imm[4:1], imm[11], opcode};
            INST_U:     word_c = {imm[31:12], rd, opcode};
            INST_J:     word_c = {imm[20], imm[10:1], imm[11], imm[19:12],
                                  rd, opcode};
            default:    word_c = '0;
        endcase
    end

endmodule

// File: rtl/inst_word_encoder.sv
// Accepts field tuples, encodes them and writes the words sequentially to IMEM.
module inst_word_encoder
    import inst_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                ready_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [INST_W-1:0]   wdata_d;
    logic                err_d;
    logic [CNT_W-1:0]    count_d;
    logic [INST_W-1:0]   word_c;
    logic                illegal_c;

    inst_field_packer u_packer (
        .inst_type (in_type),
        .opcode    (in_opcode),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .funct3    (in_funct3),
        .funct7    (in_funct7),
        .imm       (in_imm),
        .word_c    (word_c),
        .illegal_c (illegal_c)
    );

    // Next state and next register values; clear overrides all activity.
    always_comb begin
        state_d = state_q;
        addr_d  = imem_addr;
        wdata_d = imem_wdata;
        err_d   = err;
        count_d = word_count;
        if (clear) begin
            state_d = IDLE;
            addr_d  = BASE;
            err_d   = 1'b0;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (illegal_c) begin
                            err_d = 1'b1;
                        end else begin
                            wdata_d = word_c;
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (imem_ack) begin
                        addr_d  = imem_addr + ADDR_W'(1);
                        count_d = word_count + CNT_W'(1);
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        we_d    = (state_d == WRITE);
        ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= '0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            state_q    <= state_d;
            in_ready   <= ready_d;
            imem_we    <= we_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            err        <= err_d;
            word_count <= count_d;
        end
    end

endmodule

// File: tb/tb_inst_word_encoder.sv
// Scoreboard bench for inst_word_encoder with a 2-bit address space.
module tb_inst_word_encoder;

    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_type = '0;
    logic [6:0]    in_opcode = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          imem_ack = 1'b0;
    logic          err;
    logic [AW:0]   word_count;

    always #5 clk = ~clk;

    inst_word_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ack   (imem_ack),
        .err        (err),
        .word_count (word_count)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t          sb_q[$];
    logic [AW-1:0] exp_addr = '0;
    logic [AW:0]   exp_count = '0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pop and compare each acknowledged write.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && imem_we && imem_ack) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_write", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_addr", 32'(imem_addr), 32'(e.addr));
                check("sb_data", imem_wdata, e.data);
            end
        end
    end

    // Offer one tuple; ack_delay < 0 leaves the encoder waiting in WRITE.
    task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] exp_word, input bit legal, input int ack_delay);
        int waited = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
        in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (legal) begin
            sb_q.push_back(exp_t'{addr: exp_addr, data: exp_word});
            check("we_after_accept", 32'(imem_we), 32'd1);
            check("ready_in_write", 32'(in_ready), 32'd0);
            if (ack_delay < 0) return;
            for (int d = 0; d < ack_delay; d++) begin
                check("we_hold", 32'(imem_we), 32'd1);
                check("wdata_hold", imem_wdata, exp_word);
                check("addr_hold", 32'(imem_addr), 32'(exp_addr));
                @(posedge clk); #1;
            end
            imem_ack = 1'b1;
            @(posedge clk); #1;
            imem_ack = 1'b0;
            exp_addr  = exp_addr + AW'(1);
            exp_count = exp_count + (AW+1)'(1);
            check("ready_after_ack", 32'(in_ready), 32'd1);
            check("we_after_ack", 32'(imem_we), 32'd0);
        end else begin
            check("err_set", 32'(err), 32'd1);
            check("we_illegal", 32'(imem_we), 32'd0);
            check("addr_illegal", 32'(imem_addr), 32'(exp_addr));
            check("ready_illegal", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
        check({tag, "_count"}, 32'(word_count), 32'(exp_count));
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_idle_state("reset");
        check("reset_wdata", imem_wdata, 32'h0);
        check("reset_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // addi x1,x0,5 / add x3,x1,x2 / sw x2,8(x1)
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h00500093, 1'b1, 0);
        send(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3, 1'b1, 3);
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8, 32'h0020A423, 1'b1, 3);
        check("count_after_3", 32'(word_count), 32'd3);

        // beq x1,x2,-4 / jal x1,8 / lui x5,0x12345 / srai x1,x2,3 (address wraps)
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE208EE3, 1'b1, 0);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8, 32'h008000EF, 1'b1, 1);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b1, 2);
        send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3, 32'h40315093, 1'b1, 0);
        check("count_after_7", 32'(word_count), 32'd7);
        check("addr_after_7", 32'(imem_addr), 32'd3);

        // ack while idle has no effect
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        check_idle_state("stray_ack");

        // illegal type, illegal opcode, then a legal tuple with err still set
        send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1, 32'h0, 1'b0, 0);
        send(3'd0, 7'h10, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1, 32'h0, 1'b0, 0);
        check("count_after_illegal", 32'(word_count), 32'(exp_count));
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7, 32'h00700093, 1'b1, 0);
        check("err_sticky", 32'(err), 32'd1);
        check("count_wrap", 32'(word_count), 32'd0);
        check("addr_wrap", 32'(imem_addr), 32'd0);

        // clear drops err and resets address and count
        send(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd9, 32'h00900113, 1'b1, 0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_addr = '0; exp_count = '0;
        check("clear_err", 32'(err), 32'd0);
        check_idle_state("clear");

        // tuple presented with clear is dropped
        in_type = 3'd0; in_opcode = 7'h13; in_imm = 32'd1;
        in_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0;
        check_idle_state("clear_with_valid");

        // clear while waiting for ack
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h00500093, 1'b1, -1);
        clear = 1'b1;
        #3;
        check("we_before_clear_edge", 32'(imem_we), 32'd1);
        @(posedge clk); #1;
        clear = 1'b0;
        sb_q.delete();
        check_idle_state("clear_in_write");

        // reset while waiting for ack
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h00500093, 1'b1, 0);
        send(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3, 1'b1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        exp_addr = '0; exp_count = '0;
        check_idle_state("reset_in_write");
        check("reset_in_write_wdata", imem_wdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8, 32'h0020A423, 1'b1, 1);
        check("count_final", 32'(word_count), 32'd1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        check("global_timeout", 32'd0, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
